mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, max consecutive grant cycles before forced rotation when others are waiting (legal 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  4  per-requester request; bit i asserted while requester i wants the shared output.
REQ-005 Port: din  input  4  per-requester data bit; din[i] belongs to requester i.
REQ-006 Port: gnt  output  4  one-hot grant, registered; all-zero when idle.
REQ-007 Port: sel  output  2  registered index of current owner; drives the 4:1 mux select.
REQ-008 Port: y  output  1  shared output = din[sel] when valid, else 0; combinational from din.
REQ-009 Port: valid  output  1  registered; high exactly when gnt is non-zero.

Function
REQ-010 FSM states: IDLE (no owner) and OWN (one owner latched in sel/gnt).
REQ-011 Round-robin pointer ptr (2 bits): search order starts at ptr, wraps 3->0; ptr = owner+1 mod 4 whenever a grant is issued.
REQ-012 IDLE: if req != 0 at edge, next cycle OWN, owner = first set bit of req from ptr; else stay IDLE.
REQ-013 Grant latency: req rising in cycle N with no owner -> gnt/valid high in cycle N+1.
REQ-014 OWN: hold counter hcnt increments each cycle, saturating at MAX_HOLD-1; cleared to 0 on every new grant.
REQ-015 Release: req[owner] low at edge -> if other req bits set, grant next by round-robin (no dead cycle); else IDLE.
REQ-016 Timeout: hcnt == MAX_HOLD-1 with req[owner] high and any other req high -> grant next other requester by round-robin; the current owner is excluded from that search.
REQ-017 Timeout with no other requester: owner keeps grant, hcnt stays saturated, no gnt glitch.
REQ-018 Simultaneous release and timeout: treated as release (REQ-015).
REQ-019 gnt shall never have more than one bit set; sel shall equal the index of the set bit whenever valid=1.
REQ-020 y = 0 whenever valid = 0, regardless of din.
REQ-021 Requests not held until granted are simply not served; no request queuing.

Reset
REQ-022 rst high at edge: state=IDLE, gnt=0, sel=0, valid=0, hcnt=0, ptr=0; y therefore 0.
REQ-023 rst asserted mid-ownership aborts the grant on the next edge; no completion of hold period.
REQ-024 First arbitration after reset starts search at requester 0.

Structure
REQ-025 Shared package mux_arb_pkg holds NUM_REQ=4, SEL_W=2, and the state enum {IDLE, OWN}.
REQ-026 One sub-module: mux4_1 (combinational 4:1, inputs din[3:0], select sel, output raw y); gating by valid done in the parent.
REQ-027 Round-robin search implemented as one function/block reused for IDLE, release, and timeout paths.

Verification
REQ-028 Reset: rst=1 two cycles with req=4'b1111, din=4'b1111 -> gnt=0, sel=0, valid=0, y=0.
REQ-029 Single requester: req=4'b0100 from cycle 1, din[2] toggling -> cycle 2 gnt=4'b0100, sel=2, y follows din[2] same cycle; req drop -> IDLE next cycle.
REQ-030 Rotation: req=4'b1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0 each for exactly 8 cycles, no gap cycles.
REQ-031 Release handoff: owner 1, req changes 4'b0011->4'b1001 -> next cycle gnt=4'b1000 (ptr=2 search, 3 first), valid stays 1.
REQ-032 Lone timeout: req=4'b0001 for 20 cycles -> gnt=4'b0001 continuously, never drops.
REQ-033 Mid-grant reset: owner 3 at hcnt=4, rst=1 one cycle -> gnt=0 next edge; with req=4'b1000 kept, regrant to 3 one cycle after rst deasserts, hcnt restarts at 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the 4-way round-robin mux arbiter:
//   NUM_REQ / SEL_W : requester count and select width
//   arb_state_t     : arbiter FSM states (IDLE = no owner, OWN = owner latched)
//   rr_pick_t       : result of a round-robin search (found flag + index)
//   rr_search()     : the single round-robin search used for every grant path
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // Return the first set bit of mask, scanning from start upward and
    // wrapping 3->0. Walking the offsets from farthest to nearest lets the
    // nearest hit overwrite any farther one, so no priority encoder is needed.
    function automatic rr_pick_t rr_search(input logic [NUM_REQ-1:0] mask,
                                           input logic [SEL_W-1:0]   start);
        rr_pick_t         pick;
        logic [SEL_W-1:0] cand;
        pick.found = 1'b0;
        pick.idx   = {SEL_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (mask[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_1.sv
// -----------------------------------------------------------------------------
// mux4_1
// Plain combinational 4:1 bit selector. No gating: the parent decides whether
// the selected bit is meaningful.
//   din [3:0] : candidate data bits
//   sel [1:0] : index of the bit to pass
//   y         : din[sel]
// -----------------------------------------------------------------------------
module mux4_1
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] din,
    input  logic [SEL_W-1:0]   sel,
    output logic               y
);

    // Select one data bit by index
    always_comb begin
        y = 1'b0;
        case (sel)
            2'd0:    y = din[0];
            2'd1:    y = din[1];
            2'd2:    y = din[2];
            2'd3:    y = din[3];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Four requesters share one output bit. A round-robin arbiter picks an owner,
// holds it while its request stays up, and forces rotation after MAX_HOLD
// cycles if someone else is waiting.
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   req  [3:0] : per-requester request
//   din  [3:0] : per-requester data bit
//   gnt  [3:0] : registered one-hot grant, zero when idle
//   sel  [1:0] : registered owner index (mux select)
//   y          : din[sel] while valid, else 0 (combinational from din)
//   valid      : registered, high exactly when gnt is non-zero
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               y,
    output logic               valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t         state_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [SEL_W-1:0]   sel_r;
    logic               valid_r;
    logic [7:0]         hcnt_r;
    logic [SEL_W-1:0]   ptr_r;

    logic [NUM_REQ-1:0] owner_mask_s;
    logic [NUM_REQ-1:0] search_mask_s;
    logic               owner_req_s;
    rr_pick_t           pick_s;
    logic               raw_y_s;

    // Build the candidate set for the round-robin search. While the owner
    // still requests, only a timeout can move the grant, and then the owner
    // itself must be excluded. When the owner has dropped (or there is no
    // owner) its bit is already clear, so plain req is the right mask.
    always_comb begin
        owner_mask_s  = 4'b0001 << sel_r;
        owner_req_s   = |(req & owner_mask_s);
        search_mask_s = req;
        if ((state_r == OWN) && owner_req_s) begin
            search_mask_s = req & ~owner_mask_s;
        end else begin
            search_mask_s = req;
        end
        pick_s = rr_search(search_mask_s, ptr_r);
    end

    // Arbiter FSM with registered grant outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            valid_r <= 1'b0;
            hcnt_r  <= 8'd0;
            ptr_r   <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_s.found) begin
                        state_r <= OWN;
                        gnt_r   <= 4'b0001 << pick_s.idx;
                        sel_r   <= pick_s.idx;
                        valid_r <= 1'b1;
                        hcnt_r  <= 8'd0;
                        ptr_r   <= pick_s.idx + 2'd1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OWN: begin
                    // Release wins over timeout: a dropped owner always hands off.
                    if (!owner_req_s || ((hcnt_r == HOLD_LAST) && pick_s.found)) begin
                        if (pick_s.found) begin
                            state_r <= OWN;
                            gnt_r   <= 4'b0001 << pick_s.idx;
                            sel_r   <= pick_s.idx;
                            valid_r <= 1'b1;
                            hcnt_r  <= 8'd0;
                            ptr_r   <= pick_s.idx + 2'd1;
                        end else begin
                            state_r <= IDLE;
                            gnt_r   <= 4'b0000;
                            sel_r   <= 2'd0;
                            valid_r <= 1'b0;
                            hcnt_r  <= 8'd0;
                        end
                    end else if (hcnt_r != HOLD_LAST) begin
                        hcnt_r <= hcnt_r + 8'd1;
                    end else begin
                        // Timed out but nobody else waits: keep grant, stay saturated.
                        hcnt_r <= hcnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= 4'b0000;
                    sel_r   <= 2'd0;
                    valid_r <= 1'b0;
                    hcnt_r  <= 8'd0;
                end
            endcase
        end
    end

    mux4_1 u_mux (
        .din (din),
        .sel (sel_r),
        .y   (raw_y_s)
    );

    assign gnt   = gnt_r;
    assign sel   = sel_r;
    assign valid = valid_r;
    assign y     = valid_r & raw_y_s;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Self-checking bench: a behavioural owner/held-cycles model predicts the
// outputs every cycle, directed sections pin known scenarios with literal
// expectations, then randomized requests with occasional resets follow.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: current owner (-1 = none), cycles it has held, search start
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    int rot_order[5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .valid (valid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // First requester in r at or after start (mod 4), skipping index skip
    function automatic int rr_first(input logic [3:0] r, input int start, input int skip);
        int i;
        for (int off = 0; off < 4; off++) begin
            i = (start + off) % 4;
            if (i != skip && r[i[1:0]]) return i;
        end
        return -1;
    endfunction

    // Behavioural model: advance one clock edge
    always @(posedge clk) begin : model
        int nxt;
        nxt = -1;
        if (rst) begin
            m_owner <= -1;
            m_held  <= 0;
            m_ptr   <= 0;
        end else if (m_owner < 0) begin
            nxt = rr_first(req, m_ptr, -1);
            if (nxt >= 0) begin
                m_owner <= nxt; m_held <= 1; m_ptr <= (nxt + 1) % 4;
            end
        end else if (!req[m_owner[1:0]]) begin
            nxt = rr_first(req, m_ptr, -1);
            if (nxt >= 0) begin
                m_owner <= nxt; m_held <= 1; m_ptr <= (nxt + 1) % 4;
            end else begin
                m_owner <= -1; m_held <= 0;
            end
        end else if (m_held >= MH) begin
            nxt = rr_first(req, m_ptr, m_owner);
            if (nxt >= 0) begin
                m_owner <= nxt; m_held <= 1; m_ptr <= (nxt + 1) % 4;
            end
        end else begin
            m_held <= m_held + 1;
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin : compare
        logic [3:0] eg;
        logic       ev;
        logic       ey;
        if (chk_en) begin
            ev = (m_owner >= 0);
            eg = ev ? (4'b0001 << m_owner[1:0]) : 4'b0000;
            ey = ev ? din[m_owner[1:0]] : 1'b0;
            chk("cyc_valid", {31'd0, valid}, {31'd0, ev});
            chk("cyc_gnt", {28'd0, gnt}, {28'd0, eg});
            chk("cyc_y", {31'd0, y}, {31'd0, ey});
            if (ev) chk("cyc_sel", {30'd0, sel}, m_owner);
        end
    end

    initial begin
        // Reset with everything asserted
        rst = 1'b1; req = 4'b1111; din = 4'b1111;
        step(1);
        chk_en = 1'b1;
        step(1);
        chk("rst_gnt", {28'd0, gnt}, 32'h0);
        chk("rst_sel", {30'd0, sel}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'h0);
        chk("rst_y", {31'd0, y}, 32'h0);

        // Single requester 2 with din[2] toggling
        rst = 1'b0; req = 4'b0100; din = 4'b0100;
        step(1);
        chk("single_gnt", {28'd0, gnt}, 32'h4);
        chk("single_sel", {30'd0, sel}, 32'd2);
        chk("single_valid", {31'd0, valid}, 32'h1);
        chk("single_y1", {31'd0, y}, 32'h1);
        din = 4'b0000; #1;
        chk("single_y0", {31'd0, y}, 32'h0);
        din = 4'b0100; #1;
        chk("single_y1b", {31'd0, y}, 32'h1);
        req = 4'b0000; din = 4'b1111;
        step(1);
        chk("drop_valid", {31'd0, valid}, 32'h0);
        chk("drop_gnt", {28'd0, gnt}, 32'h0);
        chk("idle_y", {31'd0, y}, 32'h0);

        // Full rotation from a fresh reset
        rst = 1'b1; step(1); rst = 1'b0;
        req = 4'b1111;
        step(1);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < MH; c++) begin
                chk("rotation", {28'd0, gnt}, 32'h1 << rot_order[k]);
                step(1);
            end
        end
        chk("rot_next", {28'd0, gnt}, 32'h2);

        // Release handoff from owner 1
        req = 4'b0011; step(1);
        chk("handoff_pre", {28'd0, gnt}, 32'h2);
        req = 4'b1001; step(1);
        chk("handoff_gnt", {28'd0, gnt}, 32'h8);
        chk("handoff_valid", {31'd0, valid}, 32'h1);

        // Lone requester never loses grant past timeout
        req = 4'b0001; step(1);
        for (int c = 0; c < 20; c++) begin
            chk("lone_hold", {28'd0, gnt}, 32'h1);
            step(1);
        end

        // Reset in the middle of owner 3's hold
        req = 4'b1000; step(1);
        chk("mid_own3", {28'd0, gnt}, 32'h8);
        step(4);
        chk("mid_own3_h4", {28'd0, gnt}, 32'h8);
        rst = 1'b1; step(1);
        chk("mid_rst_gnt", {28'd0, gnt}, 32'h0);
        chk("mid_rst_valid", {31'd0, valid}, 32'h0);
        rst = 1'b0; step(1);
        chk("mid_regrant", {28'd0, gnt}, 32'h8);
        req = 4'b1001; step(7);
        chk("mid_hold_full", {28'd0, gnt}, 32'h8);
        step(1);
        chk("mid_timeout", {28'd0, gnt}, 32'h1);

        // Randomized traffic with sticky requests and rare resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            din = 4'($urandom);
            step(1);
        end
        rst = 1'b0; req = 4'b0000;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
